// File: rtl/mem_port_ctrl_pkg.sv
// Shared definitions for the memory-port controller: FSM encoding,
// acknowledge-mode selectors and the saturating wait counter helper.
package mem_port_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int ACK_FIXED     = 0;
  localparam int ACK_HANDSHAKE = 1;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // The wait counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Core-side request/done bundle and RAM-side pin bundle of the memory-port
// controller; the controller is the slave of the core and the master of the RAM.
interface mem_port_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              read_req;
  logic              write_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              bus_err;

  modport master (
    output read_req, write_req, addr, wdata,
    input  rdata, stall, done, bus_err
  );

  modport slave (
    input  read_req, write_req, addr, wdata,
    output rdata, stall, done, bus_err
  );
endinterface

interface mem_port_ctrl_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// Memory-port controller: turns held read/write requests from the control unit
// into a timed or acknowledged RAM access, stalling the core until it completes.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int ACK_MODE    = ACK_FIXED,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input logic                clk,
  input logic                reset,
  mem_port_ctrl_if.slave     cpu,
  mem_port_ctrl_bus_if.master mem
);

  // Limits are clipped to what the 4-bit counter can reach so an access always ends.
  localparam int WS_SAT = (WAIT_STATES > CNT_MAX) ? CNT_MAX : WAIT_STATES;
  localparam int TO_SAT = (TIMEOUT > CNT_MAX) ? CNT_MAX : TIMEOUT;
  localparam logic [CNT_W-1:0] WS_LIMIT = CNT_W'(WS_SAT);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TO_SAT);
  localparam bit SKIP_WAIT = (ACK_MODE == ACK_FIXED) && (WAIT_STATES == 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  countInc;
  logic              isWrite_q, isWrite_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      isWrite_q <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      isWrite_q <= isWrite_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    isWrite_d = isWrite_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    countInc  = satInc(count_q);

    case (state_q)
      IDLE: begin
        if (cpu.read_req || cpu.write_req) begin
          state_d   = ISSUE;
          addr_d    = cpu.addr;
          wdata_d   = cpu.wdata;
          isWrite_d = cpu.write_req;
          count_d   = '0;
          err_d     = 1'b0;
        end
      end

      ISSUE: begin
        if (SKIP_WAIT) begin
          state_d = DONE;
          if (!isWrite_q) rdata_d = mem.mem_rdata;
        end else begin
          state_d = WAIT;
        end
      end

      // Limits compare against the incremented count so DONE lands exactly on time.
      WAIT: begin
        count_d = countInc;
        if (ACK_MODE == ACK_HANDSHAKE) begin
          if (mem.mem_ack) begin
            state_d = DONE;
            if (!isWrite_q) rdata_d = mem.mem_rdata;
          end else if (countInc >= TO_LIMIT) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end else if (countInc >= WS_LIMIT) begin
          state_d = DONE;
          if (!isWrite_q) rdata_d = mem.mem_rdata;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem.mem_en    = (state_q == ISSUE) || (state_q == WAIT);
  assign mem.mem_we    = mem.mem_en && isWrite_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign cpu.rdata   = rdata_q;
  assign cpu.done    = (state_q == DONE);
  assign cpu.bus_err = (state_q == DONE) && err_q;
  assign cpu.stall   = ((state_q != IDLE) && (state_q != DONE)) ||
                       ((state_q == IDLE) && (cpu.read_req || cpu.write_req));

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: three instances (fixed 1 wait, fixed 0 wait,
// ack mode with timeout 4) sharing one RAM model, checked cycle by cycle.
module tb_mem_port_ctrl;
  import mem_port_ctrl_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_ctrl_if     #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cpuA ();
  mem_port_ctrl_if     #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cpuB ();
  mem_port_ctrl_if     #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cpuC ();
  mem_port_ctrl_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busA ();
  mem_port_ctrl_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busB ();
  mem_port_ctrl_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) busC ();

  mem_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACK_MODE(ACK_FIXED),
                  .WAIT_STATES(1), .TIMEOUT(15))
    dutA (.clk(clk), .reset(reset), .cpu(cpuA.slave), .mem(busA.master));

  mem_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACK_MODE(ACK_FIXED),
                  .WAIT_STATES(0), .TIMEOUT(15))
    dutB (.clk(clk), .reset(reset), .cpu(cpuB.slave), .mem(busB.master));

  mem_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACK_MODE(ACK_HANDSHAKE),
                  .WAIT_STATES(1), .TIMEOUT(4))
    dutC (.clk(clk), .reset(reset), .cpu(cpuC.slave), .mem(busC.master));

  // Shared RAM: combinational read, write on the clock edge; preload port for setup.
  logic [DATA_W-1:0] ram [512];
  logic              preWe;
  logic [ADDR_W-1:0] preAddr;
  logic [DATA_W-1:0] preData;
  logic              ackC;

  always @(posedge clk) begin
    if (preWe) ram[preAddr] <= preData;
    if (busA.mem_en && busA.mem_we) ram[busA.mem_addr] <= busA.mem_wdata;
    if (busB.mem_en && busB.mem_we) ram[busB.mem_addr] <= busB.mem_wdata;
    if (busC.mem_en && busC.mem_we) ram[busC.mem_addr] <= busC.mem_wdata;
  end

  assign busA.mem_rdata = ram[busA.mem_addr];
  assign busB.mem_rdata = ram[busB.mem_addr];
  assign busC.mem_rdata = ram[busC.mem_addr];
  assign busA.mem_ack   = 1'b0;
  assign busB.mem_ack   = 1'b0;
  assign busC.mem_ack   = ackC;

  // View of whichever instance the current test is exercising.
  int                sel;
  logic              obsStall, obsDone, obsErr, obsEn, obsWe;
  logic [DATA_W-1:0] obsRdata;
  logic [ADDR_W-1:0] obsMemAddr;

  always_comb begin
    obsStall = cpuA.stall; obsDone = cpuA.done; obsErr = cpuA.bus_err;
    obsEn = busA.mem_en; obsWe = busA.mem_we; obsRdata = cpuA.rdata; obsMemAddr = busA.mem_addr;
    if (sel == 1) begin
      obsStall = cpuB.stall; obsDone = cpuB.done; obsErr = cpuB.bus_err;
      obsEn = busB.mem_en; obsWe = busB.mem_we; obsRdata = cpuB.rdata; obsMemAddr = busB.mem_addr;
    end else if (sel == 2) begin
      obsStall = cpuC.stall; obsDone = cpuC.done; obsErr = cpuC.bus_err;
      obsEn = busC.mem_en; obsWe = busC.mem_we; obsRdata = cpuC.rdata; obsMemAddr = busC.mem_addr;
    end
  end

  int testCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    case (sel)
      0: begin cpuA.read_req = rd; cpuA.write_req = wr; cpuA.addr = a; cpuA.wdata = d; end
      1: begin cpuB.read_req = rd; cpuB.write_req = wr; cpuB.addr = a; cpuB.wdata = d; end
      default: begin cpuC.read_req = rd; cpuC.write_req = wr; cpuC.addr = a; cpuC.wdata = d; end
    endcase
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    preWe = 1'b1; preAddr = a; preData = d;
    nextCycle();
    preWe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    sel = 0; ackC = 1'b0; preWe = 1'b0; preAddr = '0; preData = '0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      applyStimulus(1'b0, 1'b0, '0, '0);
    end
    reset = 1'b1;
    repeat (3) nextCycle();
    reset = 1'b0;
    nextCycle();

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput($sformatf("reset stall %0d", s),   32'(obsStall),   32'd0);
      checkOutput($sformatf("reset done %0d", s),    32'(obsDone),    32'd0);
      checkOutput($sformatf("reset mem_en %0d", s),  32'(obsEn),      32'd0);
      checkOutput($sformatf("reset rdata %0d", s),   obsRdata,        32'd0);
      checkOutput($sformatf("reset mem_addr %0d", s), 32'(obsMemAddr), 32'd0);
    end

    // Fixed mode, one wait state: read of 0x05.
    sel = 0;
    preload(9'h005, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 9'h005, '0);
    checkOutput("t1 c0 stall", 32'(obsStall), 32'd1);
    checkOutput("t1 c0 done", 32'(obsDone), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h007, '0);
    checkOutput("t1 c1 mem_en", 32'(obsEn), 32'd1);
    checkOutput("t1 c1 mem_we", 32'(obsWe), 32'd0);
    checkOutput("t1 c1 mem_addr", 32'(obsMemAddr), 32'h005);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h007, '0);
    checkOutput("t1 c2 stall", 32'(obsStall), 32'd1);
    checkOutput("t1 c2 done", 32'(obsDone), 32'd0);
    checkOutput("t1 c2 mem_addr", 32'(obsMemAddr), 32'h005);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t1 c3 done", 32'(obsDone), 32'd1);
    checkOutput("t1 c3 bus_err", 32'(obsErr), 32'd0);
    checkOutput("t1 c3 stall", 32'(obsStall), 32'd0);
    checkOutput("t1 c3 mem_en", 32'(obsEn), 32'd0);
    checkOutput("t1 c3 rdata", obsRdata, 32'hDEADBEEF);
    nextCycle();
    checkOutput("t1 c4 done", 32'(obsDone), 32'd0);

    // Fixed mode, zero wait states: write 0x1234 to 0x1FF, request held past DONE.
    sel = 1;
    applyStimulus(1'b0, 1'b1, 9'h1FF, 32'h0000_1234);
    checkOutput("t2 c0 stall", 32'(obsStall), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 9'h1FF, 32'h0000_1234);
    checkOutput("t2 c1 mem_en", 32'(obsEn), 32'd1);
    checkOutput("t2 c1 mem_we", 32'(obsWe), 32'd1);
    checkOutput("t2 c1 mem_addr", 32'(obsMemAddr), 32'h1FF);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 9'h1FF, 32'h0000_1234);
    checkOutput("t2 c2 done", 32'(obsDone), 32'd1);
    checkOutput("t2 c2 mem_we", 32'(obsWe), 32'd0);
    checkOutput("t2 c2 ram", ram[9'h1FF], 32'h0000_1234);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 9'h1FF, 32'h0000_1234);
    checkOutput("t2 c3 idle mem_en", 32'(obsEn), 32'd0);
    checkOutput("t2 c3 idle stall", 32'(obsStall), 32'd1);
    checkOutput("t2 c3 done", 32'(obsDone), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t2 c4 reissue mem_we", 32'(obsWe), 32'd1);
    nextCycle();
    checkOutput("t2 c5 done", 32'(obsDone), 32'd1);
    nextCycle();

    // Ack mode: ack in ISSUE is ignored, ack in the third WAIT cycle completes.
    sel = 2;
    preload(9'h010, 32'hA5A5A5A5);
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    nextCycle();
    ackC = 1'b1;
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    checkOutput("t3 c1 mem_en", 32'(obsEn), 32'd1);
    nextCycle();
    ackC = 1'b0;
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    checkOutput("t3 c2 done", 32'(obsDone), 32'd0);
    checkOutput("t3 c2 mem_en", 32'(obsEn), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    checkOutput("t3 c3 done", 32'(obsDone), 32'd0);
    nextCycle();
    ackC = 1'b1;
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    checkOutput("t3 c4 done", 32'(obsDone), 32'd0);
    checkOutput("t3 c4 stall", 32'(obsStall), 32'd1);
    nextCycle();
    ackC = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t3 c5 done", 32'(obsDone), 32'd1);
    checkOutput("t3 c5 bus_err", 32'(obsErr), 32'd0);
    checkOutput("t3 c5 rdata", obsRdata, 32'hA5A5A5A5);
    nextCycle();

    // Ack mode timeout (4): no ack, done and bus_err in cycle 6, rdata kept.
    preload(9'h020, 32'h1111_1111);
    applyStimulus(1'b1, 1'b0, 9'h020, '0);
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      applyStimulus(1'b1, 1'b0, 9'h020, '0);
      checkOutput($sformatf("t4 c%0d done", c), 32'(obsDone), 32'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t4 c6 done", 32'(obsDone), 32'd1);
    checkOutput("t4 c6 bus_err", 32'(obsErr), 32'd1);
    checkOutput("t4 c6 rdata", obsRdata, 32'hA5A5A5A5);
    nextCycle();
    checkOutput("t4 c7 bus_err", 32'(obsErr), 32'd0);

    // Both requests high: write wins, rdata unchanged.
    sel = 0;
    preload(9'h030, 32'h7777_7777);
    applyStimulus(1'b1, 1'b1, 9'h030, 32'hCAFE_0001);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'h030, 32'hCAFE_0001);
    checkOutput("t5 c1 mem_we", 32'(obsWe), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'h030, 32'hCAFE_0001);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t5 c3 done", 32'(obsDone), 32'd1);
    checkOutput("t5 c3 rdata", obsRdata, 32'hDEADBEEF);
    nextCycle();
    checkOutput("t5 ram", ram[9'h030], 32'hCAFE_0001);

    // Reset during WAIT aborts the access with no done.
    sel = 2;
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h010, '0);
    checkOutput("t6 c2 mem_en", 32'(obsEn), 32'd1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t6 c3 mem_en", 32'(obsEn), 32'd0);
    checkOutput("t6 c3 mem_we", 32'(obsWe), 32'd0);
    checkOutput("t6 c3 done", 32'(obsDone), 32'd0);
    checkOutput("t6 c3 stall", 32'(obsStall), 32'd0);
    checkOutput("t6 c3 rdata", obsRdata, 32'd0);
    checkOutput("t6 c3 mem_addr", 32'(obsMemAddr), 32'd0);
    for (int c = 4; c <= 5; c++) begin
      nextCycle();
      checkOutput($sformatf("t6 c%0d done", c), 32'(obsDone), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
